wave_cfg_scheduler: RTL and testbench



---
 rtl/wave_cfg_scheduler.sv | 166 ++++++++++++++++
 tb/tb_wave_cfg_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_cfg_scheduler.sv
// Function-generator sequencer: debounced switch config, prescaled ROM address walk, wrap-aligned reconfiguration.
// Latency: switch acceptance 2+STABLE_CYCLES cycles; div/wave change lands on the next 1023->0 wrap (at once on hold or start).
// Backpressure: none; a newer switch candidate overwrites a waiting one, INIT low stops the walk at the next edge.
module wave_cfg_scheduler #(
    parameter int ADDR_W        = 10,
    parameter int DIV_W         = 8,
    parameter int STABLE_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INIT,
    input  logic [11:0]       SW,
    output logic [ADDR_W-1:0] MEMORYCOUNTER,
    output logic [2:0]        WAVESELECT,
    output logic              STEP_EN,
    output logic              CO,
    output logic              CFG_BUSY
);

    localparam int                 CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ARM  = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [ADDR_W-1:0]  ADDR_MAX = '1;

    typedef struct packed {
        logic [2:0]       wave;
        logic [DIV_W-1:0] div;
    } dw_t;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_WRAP = 2'd2
    } state_t;

    logic [11:0]      sw_m;
    logic [11:0]      sw_s;
    logic [11:0]      sw_p;
    logic [CNT_W-1:0] stab_cnt;

    state_t           state;
    state_t           state_nxt;
    logic             hold;
    dw_t              act;
    dw_t              pend;
    dw_t              pend_nxt;
    logic             pend_vld;
    logic             pend_vld_nxt;
    logic [DIV_W-1:0] pre;

    logic             running;
    logic             sw_same;
    logic             accept;
    dw_t              cand_dw;
    dw_t              eff_dw;
    logic             cand_new;
    logic             step;
    logic             wrap;
    logic             load;

    assign running  = (state != ST_OFF);
    assign sw_same  = (sw_s == sw_p);
    assign accept   = sw_same && (stab_cnt == CNT_ARM);
    assign cand_dw  = {sw_s[10:8], sw_s[DIV_W-1:0]};

    // >= rather than == so a divisor lowered below the running prescale still fires
    assign step     = running && !hold && (pre >= act.div);
    assign wrap     = step && (MEMORYCOUNTER == ADDR_MAX);

    assign load     = INIT && pend_vld &&
                      ((state == ST_OFF) || (running && hold) || ((state == ST_WAIT_WRAP) && wrap));

    // A candidate accepted on a load edge is judged against the config being loaded
    assign eff_dw   = load ? pend : act;
    assign cand_new = (cand_dw != eff_dw);

    assign STEP_EN    = step;
    assign WAVESELECT = act.wave;
    assign CFG_BUSY   = (state == ST_WAIT_WRAP);

    always_comb begin
        pend_nxt     = pend;
        pend_vld_nxt = pend_vld;
        if (load) begin
            pend_vld_nxt = 1'b0;
        end
        if (accept) begin
            pend_vld_nxt = cand_new;
            if (cand_new) begin
                pend_nxt = cand_dw;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (!INIT) begin
            state_nxt = ST_OFF;
        end else begin
            case (state)
                ST_OFF: state_nxt = ST_RUN;
                ST_RUN: begin
                    if (!hold && pend_vld && pend_vld_nxt) begin
                        state_nxt = ST_WAIT_WRAP;
                    end
                end
                ST_WAIT_WRAP: begin
                    if (hold || wrap || !pend_vld_nxt) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sw_m          <= '0;
            sw_s          <= '0;
            sw_p          <= '0;
            stab_cnt      <= '0;
            state         <= ST_OFF;
            hold          <= 1'b0;
            act           <= '0;
            pend          <= '0;
            pend_vld      <= 1'b0;
            pre           <= '0;
            MEMORYCOUNTER <= '0;
            CO            <= 1'b0;
        end else begin
            sw_m <= SW;
            sw_s <= sw_m;
            sw_p <= sw_s;

            if (!sw_same) begin
                stab_cnt <= '0;
            end else if (stab_cnt != CNT_MAX) begin
                stab_cnt <= stab_cnt + CNT_W'(1);
            end

            if (accept) begin
                hold <= sw_s[11];
            end
            if (load) begin
                act <= pend;
            end
            pend     <= pend_nxt;
            pend_vld <= pend_vld_nxt;
            state    <= state_nxt;

            CO <= INIT && wrap;

            if (!INIT || (state == ST_OFF)) begin
                MEMORYCOUNTER <= '0;
                pre           <= '0;
            end else if (step) begin
                MEMORYCOUNTER <= MEMORYCOUNTER + ADDR_W'(1);
                pre           <= '0;
            end else if (!hold) begin
                pre <= pre + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wave_cfg_scheduler.sv
// Bench for wave_cfg_scheduler: directed scenario steps plus random switch activity,
// every cycle compared against a behavioural model of the switch/config/address rules.
module tb_wave_cfg_scheduler;

    localparam int ADDR_W        = 10;
    localparam int DIV_W         = 8;
    localparam int STABLE_CYCLES = 16;
    localparam int AMAX          = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              init;
    logic [11:0]       sw;
    logic [ADDR_W-1:0] MEMORYCOUNTER;
    logic [2:0]        WAVESELECT;
    logic              STEP_EN;
    logic              CO;
    logic              CFG_BUSY;

    int n_checks = 0;
    int n_errors = 0;

    wave_cfg_scheduler #(
        .ADDR_W        (ADDR_W),
        .DIV_W         (DIV_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .INIT          (init),
        .SW            (sw),
        .MEMORYCOUNTER (MEMORYCOUNTER),
        .WAVESELECT    (WAVESELECT),
        .STEP_EN       (STEP_EN),
        .CO            (CO),
        .CFG_BUSY      (CFG_BUSY)
    );

    always #5 clk = ~clk;

    // Reference model: running/waiting flags, integer address and phase, active and pending config
    bit          m_run, m_wait, m_hold, m_pv, m_co;
    int          m_addr, m_phase, m_div, m_wave, m_pdiv, m_pwave, m_same;
    logic [11:0] m_pipe0, m_pipe1, m_prev;

    function automatic void model_reset();
        m_run = 0; m_wait = 0; m_hold = 0; m_pv = 0; m_co = 0;
        m_addr = 0; m_phase = 0; m_div = 0; m_wave = 0; m_pdiv = 0; m_pwave = 0; m_same = 0;
        m_pipe0 = '0; m_pipe1 = '0; m_prev = '0;
    endfunction

    function automatic void take_pending();
        m_wave = m_pwave;
        m_div  = m_pdiv;
        m_pv   = 0;
    endfunction

    function automatic bit model_step_en();
        return m_run && !m_hold && (m_phase >= m_div);
    endfunction

    function automatic void model_edge(input bit init_i, input logic [11:0] sw_i);
        bit          stepping, wrapped, acc, pv0, hold0, was_run, was_wait;
        logic [11:0] cand;
        stepping = model_step_en();
        wrapped  = stepping && (m_addr == AMAX);
        pv0 = m_pv; hold0 = m_hold; was_run = m_run; was_wait = m_wait;
        cand = m_pipe1;
        acc  = 0;
        if (m_pipe1 == m_prev) begin
            m_same++;
            acc = (m_same == STABLE_CYCLES - 1);
        end else begin
            m_same = 0;
        end
        m_prev = m_pipe1; m_pipe1 = m_pipe0; m_pipe0 = sw_i;
        m_co = 0;
        if (!init_i) begin
            m_run = 0; m_wait = 0; m_addr = 0; m_phase = 0;
        end else if (!was_run) begin
            if (pv0) take_pending();
            m_run = 1; m_addr = 0; m_phase = 0;
        end else if (hold0) begin
            if (pv0) take_pending();
            m_wait = 0;
        end else begin
            if (stepping) begin
                m_addr = (m_addr + 1) % (AMAX + 1);
                m_phase = 0;
            end else begin
                m_phase++;
            end
            if (wrapped) begin
                m_co = 1;
                if (was_wait && pv0) take_pending();
                if (was_wait) m_wait = 0;
            end
        end
        if (acc) begin
            m_hold = cand[11];
            if (int'(cand[10:8]) == m_wave && int'(cand[DIV_W-1:0]) == m_div) begin
                m_pv = 0;
            end else begin
                m_pv = 1;
                m_pwave = int'(cand[10:8]);
                m_pdiv  = int'(cand[DIV_W-1:0]);
            end
        end
        if (init_i && was_run && !hold0 && !(wrapped && was_wait))
            m_wait = was_wait ? m_pv : (pv0 && m_pv);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
            if (n_errors >= 40) begin
                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
                $fatal(1, "stopping after too many errors");
            end
        end
    endtask

    task automatic tick();
        model_edge(init, sw);
        @(posedge clk);
        #1;
        check("cyc_addr", 32'(MEMORYCOUNTER), 32'(m_addr));
        check("cyc_wave", 32'(WAVESELECT), 32'(m_wave));
        check("cyc_step", 32'(STEP_EN), 32'(model_step_en()));
        check("cyc_co", 32'(CO), 32'(m_co));
        check("cyc_busy", 32'(CFG_BUSY), 32'(m_wait));
    endtask

    initial begin
        int         n, steps, frozen, last_wave, gap, toggles, period, bitpos;
        bit         any_busy;
        logic [2:0] hw, w2;
        logic [7:0] hd, d2;

        rst = 1'b1; init = 1'b0; sw = 12'h102;
        model_reset();
        #2;
        check("rst_addr", 32'(MEMORYCOUNTER), 0);
        check("rst_wave", 32'(WAVESELECT), 0);
        check("rst_step", 32'(STEP_EN), 0);
        check("rst_co", 32'(CO), 0);
        check("rst_busy", 32'(CFG_BUSY), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Start: 0x102 settles while stopped, then loads on the INIT edge
        repeat (40) tick();
        init = 1'b1;
        tick();
        check("start_wave", 32'(WAVESELECT), 1);
        n = 0; steps = 0;
        while (CO !== 1'b1 && n < 4000) begin
            tick();
            n++;
            if (STEP_EN === 1'b1) steps++;
        end
        check("start_co_cycles", n, 3072);
        check("start_steps", steps, 1024);

        // Deferred switch to 0x305 from address 100
        n = 0;
        while (MEMORYCOUNTER != 10'd100 && n < 1000) begin tick(); n++; end
        check("defer_at100", 32'(MEMORYCOUNTER), 100);
        sw = 12'h305;
        n = 0;
        while (CFG_BUSY !== 1'b1 && n < 100) begin tick(); n++; end
        check("defer_busy_latency", n, STABLE_CYCLES + 3);
        n = 0; last_wave = int'(WAVESELECT);
        while (CO !== 1'b1 && n < 4000) begin
            last_wave = int'(WAVESELECT);
            tick();
            n++;
        end
        check("defer_wave_before", last_wave, 1);
        check("defer_wave_after", 32'(WAVESELECT), 3);
        check("defer_addr_wrap", 32'(MEMORYCOUNTER), 0);
        check("defer_busy_clear", 32'(CFG_BUSY), 0);
        n = 0;
        while (STEP_EN !== 1'b1 && n < 20) begin tick(); n++; end
        gap = 0;
        do begin tick(); gap++; end while (STEP_EN !== 1'b1 && gap < 20);
        check("defer_step_gap", gap, 6);

        // Bounce on one wave bit, always faster than the stability window
        bitpos = $urandom_range(8, 10);
        period = $urandom_range(3, 8);
        toggles = 2 * (100 / period);
        any_busy = 0;
        for (int i = 0; i < toggles; i++) begin
            sw[bitpos] = ~sw[bitpos];
            repeat (period) begin
                tick();
                any_busy = any_busy | (CFG_BUSY === 1'b1);
            end
        end
        sw = 12'h305;
        repeat (30) begin
            tick();
            any_busy = any_busy | (CFG_BUSY === 1'b1);
        end
        check("bounce_busy", 32'(any_busy), 0);
        check("bounce_wave", 32'(WAVESELECT), 3);

        // Cancel: a different setting, then back to the active one before the wrap
        n = 0;
        while ((MEMORYCOUNTER < 10'd100 || MEMORYCOUNTER > 10'd900) && n < 8000) begin tick(); n++; end
        d2 = 8'($urandom_range(0, 7));
        w2 = 3'($urandom_range(0, 7));
        if (w2 == 3'd3 && d2 == 8'd5) w2 = 3'd4;
        sw = {1'b0, w2, d2};
        repeat (25) tick();
        check("cancel_busy_set", 32'(CFG_BUSY), 1);
        sw = 12'h305;
        repeat (25) tick();
        check("cancel_busy_clear", 32'(CFG_BUSY), 0);
        n = 0;
        while (CO !== 1'b1 && n < 7000) begin tick(); n++; end
        check("cancel_co_seen", 32'(CO), 1);
        check("cancel_wave_kept", 32'(WAVESELECT), 3);

        // Hold: pending wave applies at once, address freezes, then resumes
        n = 0;
        while ((MEMORYCOUNTER < 10'd100 || MEMORYCOUNTER > 10'd800) && n < 8000) begin tick(); n++; end
        hw = 3'(($urandom_range(1, 7) + 3) % 8);
        hd = 8'($urandom_range(0, 4));
        sw = {1'b0, hw, hd};
        n = 0;
        while (CFG_BUSY !== 1'b1 && n < 100) begin tick(); n++; end
        check("hold_pending", 32'(CFG_BUSY), 1);
        sw = {1'b1, hw, hd};
        repeat (22) tick();
        check("hold_step", 32'(STEP_EN), 0);
        check("hold_wave", 32'(WAVESELECT), 32'(hw));
        check("hold_busy", 32'(CFG_BUSY), 0);
        frozen = m_addr;
        repeat (10) tick();
        check("hold_frozen", 32'(MEMORYCOUNTER), frozen);
        sw = {1'b0, hw, hd};
        n = 0;
        while (int'(MEMORYCOUNTER) == frozen && n < 60) begin tick(); n++; end
        check("hold_resume", 32'(MEMORYCOUNTER), (frozen + 1) % (AMAX + 1));

        // INIT drop at address 500
        n = 0;
        while (MEMORYCOUNTER != 10'd500 && n < 12000) begin tick(); n++; end
        check("init_at500", 32'(MEMORYCOUNTER), 500);
        init = 1'b0;
        tick();
        check("init_off_addr", 32'(MEMORYCOUNTER), 0);
        check("init_off_co", 32'(CO), 0);
        check("init_off_step", 32'(STEP_EN), 0);
        repeat (5) tick();
        init = 1'b1;
        repeat (5) tick();

        // Reset while waiting for the wrap
        w2 = hw + 3'd1;
        d2 = hd;
        sw = {1'b0, w2, d2};
        n = 0;
        while (CFG_BUSY !== 1'b1 && n < 100) begin tick(); n++; end
        check("rst_wait_busy", 32'(CFG_BUSY), 1);
        rst = 1'b1; init = 1'b0;
        #2;
        check("midrst_addr", 32'(MEMORYCOUNTER), 0);
        check("midrst_wave", 32'(WAVESELECT), 0);
        check("midrst_step", 32'(STEP_EN), 0);
        check("midrst_co", 32'(CO), 0);
        check("midrst_busy", 32'(CFG_BUSY), 0);
        #2;
        rst = 1'b0;
        model_reset();
        repeat (30) tick();
        check("off_idle_busy", 32'(CFG_BUSY), 0);
        init = 1'b1;
        tick();
        check("restart_wave", 32'(WAVESELECT), 32'(w2));

        // Random switch and run-enable activity
        for (int r = 0; r < 14; r++) begin
            sw = {($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 2))};
            if ($urandom_range(0, 5) == 0) init = ~init;
            if (r == 13) init = 1'b1;
            repeat ($urandom_range(10, 1200)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
